dp_ram_pipe: RTL and testbench

DP_RAM_PIPE -- requirements
Module: dp_ram_pipe

---
 rtl/dp_ram_pipe_pkg.sv | 12 +
 rtl/dp_ram_delay.sv | 49 ++++
 rtl/dp_ram_pipe.sv | 139 +++++++++++++
 tb/tb_dp_ram_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pipe_pkg.sv
// Shared types and limits for the pipelined dual-port RAM.
// Read/commit ordering modes and the latency ceiling live here.
package dp_ram_pipe_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } rd_mode_e;

    localparam int MAX_LATENCY = 8;

endpackage

// File: rtl/dp_ram_delay.sv
// N-stage valid+payload register delay, all stages cleared on reset.
// Latency N cycles (N=0 is a wire); no backpressure, accepts a beat every cycle.
module dp_ram_delay #(
    parameter int N = 1,
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);

    generate
        if (N == 0) begin : g_pass
            assign o_vld = i_vld;
            assign o_dat = i_dat;
        end else begin : g_pipe
            logic [N-1:0] vld_q;
            logic [N-1:0] vld_d;
            logic [W-1:0] dat_q [N];
            logic [W-1:0] dat_d [N];

            always_comb begin
                vld_d[0] = i_vld;
                dat_d[0] = i_dat;
                for (int i = 1; i < N; i++) begin
                    vld_d[i] = vld_q[i-1];
                    dat_d[i] = dat_q[i-1];
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < N; i++) dat_q[i] <= '0;
                end else begin
                    vld_q <= vld_d;
                    for (int i = 0; i < N; i++) dat_q[i] <= dat_d[i];
                end
            end

            assign o_vld = vld_q[N-1];
            assign o_dat = dat_q[N-1];
        end
    endgenerate

endmodule

// File: rtl/dp_ram_pipe.sv
// Dual-port byte-writable RAM with fixed read/write pipeline latencies.
// No backpressure: one request per port per cycle; pending writes are not forwarded.
module dp_ram_pipe
    import dp_ram_pipe_pkg::*;
#(
    parameter int       ADDR_WIDTH    = 4,
    parameter int       DATA_WIDTH    = 8,
    parameter int       READ_LATENCY  = 3,
    parameter int       WRITE_LATENCY = 3,
    parameter rd_mode_e RD_MODE       = READ_FIRST
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ena,
    input  logic                    i_enb,
    input  logic                    i_wea,
    input  logic                    i_web,
    input  logic [DATA_WIDTH/8-1:0] i_bea,
    input  logic [DATA_WIDTH/8-1:0] i_beb,
    input  logic [ADDR_WIDTH-1:0]   i_addra,
    input  logic [ADDR_WIDTH-1:0]   i_addrb,
    input  logic [DATA_WIDTH-1:0]   i_dina,
    input  logic [DATA_WIDTH-1:0]   i_dinb,
    output logic [DATA_WIDTH-1:0]   o_douta,
    output logic [DATA_WIDTH-1:0]   o_doutb,
    output logic                    o_valida,
    output logic                    o_validb,
    output logic                    o_collision
);

    localparam int BW    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int WPW   = BW + ADDR_WIDTH + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wra_vld, wrb_vld, rda_vld, rdb_vld;
    logic                  cma_vld, cmb_vld, rqa_vld, rqb_vld;
    logic [WPW-1:0]        cma_dat, cmb_dat;
    logic [BW-1:0]         cma_be, cmb_be;
    logic [ADDR_WIDTH-1:0] cma_addr, cmb_addr;
    logic [DATA_WIDTH-1:0] cma_din, cmb_din;
    logic [DATA_WIDTH-1:0] wr_a_word, wr_b_word, rda_word, rdb_word;
    logic [DATA_WIDTH-1:0] rqa_dat, rqb_dat;
    logic [DATA_WIDTH-1:0] douta_d, douta_q, doutb_d, doutb_q;
    logic                  valida_d, valida_q, validb_d, validb_q;
    logic                  collision_d, collision_q;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [BW-1:0]         be,
        input logic [DATA_WIDTH-1:0] din
    );
        logic [DATA_WIDTH-1:0] w;
        w = old_w;
        for (int i = 0; i < BW; i++) begin
            if (be[i]) w[i*8 +: 8] = din[i*8 +: 8];
        end
        return w;
    endfunction

    // Gate with reset so a zero-latency path cannot sample during reset.
    assign wra_vld = i_rst_n & i_ena & i_wea;
    assign wrb_vld = i_rst_n & i_enb & i_web;
    assign rda_vld = i_rst_n & i_ena & ~i_wea;
    assign rdb_vld = i_rst_n & i_enb & ~i_web;

    dp_ram_delay #(.N(WRITE_LATENCY - 1), .W(WPW)) u_wr_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(wra_vld),
        .i_dat({i_bea, i_addra, i_dina}), .o_vld(cma_vld), .o_dat(cma_dat)
    );
    dp_ram_delay #(.N(WRITE_LATENCY - 1), .W(WPW)) u_wr_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(wrb_vld),
        .i_dat({i_beb, i_addrb, i_dinb}), .o_vld(cmb_vld), .o_dat(cmb_dat)
    );

    assign {cma_be, cma_addr, cma_din} = cma_dat;
    assign {cmb_be, cmb_addr, cmb_din} = cmb_dat;

    // Port A's word already folds in B's bytes on a same-address commit, so A wins.
    always_comb begin
        wr_b_word = merge_bytes(mem_q[cmb_addr], cmb_be, cmb_din);
        wr_a_word = merge_bytes((cmb_vld && cmb_addr == cma_addr) ? wr_b_word : mem_q[cma_addr],
                                cma_be, cma_din);
        rda_word  = mem_q[i_addra];
        rdb_word  = mem_q[i_addrb];
        if (RD_MODE == WRITE_FIRST) begin
            if (cmb_vld && cmb_addr == i_addra) rda_word = wr_b_word;
            if (cma_vld && cma_addr == i_addra) rda_word = wr_a_word;
            if (cmb_vld && cmb_addr == i_addrb) rdb_word = wr_b_word;
            if (cma_vld && cma_addr == i_addrb) rdb_word = wr_a_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (cmb_vld) mem_q[cmb_addr] <= wr_b_word;
        if (cma_vld) mem_q[cma_addr] <= wr_a_word;
    end

    dp_ram_delay #(.N(READ_LATENCY - 1), .W(DATA_WIDTH)) u_rd_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(rda_vld),
        .i_dat(rda_word), .o_vld(rqa_vld), .o_dat(rqa_dat)
    );
    dp_ram_delay #(.N(READ_LATENCY - 1), .W(DATA_WIDTH)) u_rd_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(rdb_vld),
        .i_dat(rdb_word), .o_vld(rqb_vld), .o_dat(rqb_dat)
    );

    always_comb begin
        douta_d     = rqa_vld ? rqa_dat : douta_q;
        doutb_d     = rqb_vld ? rqb_dat : doutb_q;
        valida_d    = rqa_vld;
        validb_d    = rqb_vld;
        collision_d = cma_vld & cmb_vld & (cma_addr == cmb_addr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            douta_q     <= '0;
            doutb_q     <= '0;
            valida_q    <= 1'b0;
            validb_q    <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            douta_q     <= douta_d;
            doutb_q     <= doutb_d;
            valida_q    <= valida_d;
            validb_q    <= validb_d;
            collision_q <= collision_d;
        end
    end

    assign o_douta     = douta_q;
    assign o_doutb     = doutb_q;
    assign o_valida    = valida_q;
    assign o_validb    = validb_q;
    assign o_collision = collision_q;

endmodule

// File: tb/tb_dp_ram_pipe.sv
// Bench for dp_ram_pipe: default 8-bit READ_FIRST instance plus a 16-bit WRITE_FIRST instance.
module tb_dp_ram_pipe;
    import dp_ram_pipe_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       ena, wea, enb, web, valida, validb, col;
    logic [0:0] bea, beb;
    logic [3:0] addra, addrb;
    logic [7:0] dina, dinb, douta, doutb;

    logic        w_ena, w_wea, w_enb, w_web, w_valida, w_validb, w_col;
    logic [1:0]  w_bea, w_beb;
    logic [3:0]  w_addra, w_addrb;
    logic [15:0] w_dina, w_dinb, w_douta, w_doutb;

    dp_ram_pipe u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
        .i_bea(bea), .i_beb(beb), .i_addra(addra), .i_addrb(addrb), .i_dina(dina), .i_dinb(dinb),
        .o_douta(douta), .o_doutb(doutb), .o_valida(valida), .o_validb(validb), .o_collision(col)
    );

    dp_ram_pipe #(.DATA_WIDTH(16), .RD_MODE(WRITE_FIRST)) u_dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(w_ena), .i_enb(w_enb), .i_wea(w_wea), .i_web(w_web),
        .i_bea(w_bea), .i_beb(w_beb), .i_addra(w_addra), .i_addrb(w_addrb),
        .i_dina(w_dina), .i_dinb(w_dinb), .o_douta(w_douta), .o_doutb(w_doutb),
        .o_valida(w_valida), .o_validb(w_validb), .o_collision(w_col)
    );

    int checks   = 0;
    int failures = 0;

    // op codes: 0 idle, 1 read, 2 write (be=1), 3 write with be=0
    typedef struct {
        int opa; logic [3:0] aa; logic [7:0] da;
        int opb; logic [3:0] ab; logic [7:0] db;
        logic va; logic [7:0] xa; logic vb; logic [7:0] xb; logic xc;
    } vec_t;
    vec_t tbl[30];

    typedef struct { logic v; logic be; logic [3:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic v; logic [7:0] d; } rd_t;
    wr_t pwa[4], pwb[4];
    rd_t pra[4], prb[4];
    logic [7:0] mmem[16];
    logic [7:0] mda, mdb;
    bit ka, kb;
    int e;

    function automatic vec_t mk(int opa, logic [3:0] aa, logic [7:0] da, int opb, logic [3:0] ab,
                                logic [7:0] db, logic va, logic [7:0] xa, logic vb, logic [7:0] xb,
                                logic xc);
        vec_t v;
        v.opa = opa; v.aa = aa; v.da = da; v.opb = opb; v.ab = ab; v.db = db;
        v.va = va; v.xa = xa; v.vb = vb; v.xb = xb; v.xc = xc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int opa, input logic [3:0] aa, input logic [7:0] da,
                       input int opb, input logic [3:0] ab, input logic [7:0] db);
        ena = (opa != 0); wea = (opa >= 2); bea = (opa == 2); addra = aa; dina = da;
        enb = (opb != 0); web = (opb >= 2); beb = (opb == 2); addrb = ab; dinb = db;
    endtask

    task automatic wcyc(input int opa, input logic [1:0] bea_i, input logic [3:0] aa,
                        input logic [15:0] da, input int opb, input logic [1:0] beb_i,
                        input logic [3:0] ab, input logic [15:0] db);
        w_ena = (opa != 0); w_wea = (opa == 2); w_bea = bea_i; w_addra = aa; w_dina = da;
        w_enb = (opb != 0); w_web = (opb == 2); w_beb = beb_i; w_addrb = ab; w_dinb = db;
        tick();
    endtask

    // Reference model: writes commit two edges after sampling, reads sample the array
    // at their own edge before that edge's commits (READ_FIRST), data appears two edges later.
    task automatic rstep(input int opa, input logic [3:0] aa, input logic [7:0] da,
                         input int opb, input logic [3:0] ab, input logic [7:0] db);
        int s, c;
        logic xcol;
        drv(opa, aa, da, opb, ab, db);
        @(posedge clk);
        s = e % 4;
        c = (e + 2) % 4;
        pra[s].v = (opa == 1); pra[s].d = mmem[aa];
        prb[s].v = (opb == 1); prb[s].d = mmem[ab];
        xcol = pwa[c].v && pwb[c].v && (pwa[c].a == pwb[c].a);
        if (pwb[c].v && pwb[c].be) mmem[pwb[c].a] = pwb[c].d;
        if (pwa[c].v && pwa[c].be) mmem[pwa[c].a] = pwa[c].d;
        pwa[s].v = (opa >= 2); pwa[s].be = (opa == 2); pwa[s].a = aa; pwa[s].d = da;
        pwb[s].v = (opb >= 2); pwb[s].be = (opb == 2); pwb[s].a = ab; pwb[s].d = db;
        if (pra[c].v) begin mda = pra[c].d; ka = 1; end
        if (prb[c].v) begin mdb = prb[c].d; kb = 1; end
        #1;
        chk("rnd valida", valida, pra[c].v);
        chk("rnd validb", validb, prb[c].v);
        chk("rnd collision", col, xcol);
        if (ka) chk("rnd douta", douta, mda);
        if (kb) chk("rnd doutb", doutb, mdb);
        e++;
    endtask

    initial begin
        //          opa aa  da     opb ab  db     va xa     vb xb     col
        tbl[0]  = mk(2, 5, 8'hA5, 0, 0, 0,     0, 8'h00, 0, 8'h00, 0);
        tbl[1]  = mk(0, 0, 0,     0, 0, 0,     0, 8'h00, 0, 8'h00, 0);
        tbl[2]  = mk(0, 0, 0,     0, 0, 0,     0, 8'h00, 0, 8'h00, 0);
        tbl[3]  = mk(0, 0, 0,     1, 5, 0,     0, 8'h00, 0, 8'h00, 0);
        tbl[4]  = mk(0, 0, 0,     0, 0, 0,     0, 8'h00, 0, 8'h00, 0);
        tbl[5]  = mk(0, 0, 0,     0, 0, 0,     0, 8'h00, 1, 8'hA5, 0);
        tbl[6]  = mk(0, 0, 0,     0, 0, 0,     0, 8'h00, 0, 8'hA5, 0);
        tbl[7]  = mk(2, 7, 8'h11, 2, 7, 8'h22, 0, 8'h00, 0, 8'hA5, 0);
        tbl[8]  = mk(2, 3, 8'h00, 0, 0, 0,     0, 8'h00, 0, 8'hA5, 0);
        tbl[9]  = mk(0, 0, 0,     0, 0, 0,     0, 8'h00, 0, 8'hA5, 1);
        tbl[10] = mk(0, 0, 0,     0, 0, 0,     0, 8'h00, 0, 8'hA5, 0);
        tbl[11] = mk(2, 3, 8'h5A, 0, 0, 0,     0, 8'h00, 0, 8'hA5, 0);
        tbl[12] = mk(1, 7, 0,     0, 0, 0,     0, 8'h00, 0, 8'hA5, 0);
        tbl[13] = mk(0, 0, 0,     1, 3, 0,     0, 8'h00, 0, 8'hA5, 0);
        tbl[14] = mk(1, 3, 0,     0, 0, 0,     1, 8'h11, 0, 8'hA5, 0);
        tbl[15] = mk(0, 0, 0,     0, 0, 0,     0, 8'h11, 1, 8'h00, 0);
        tbl[16] = mk(0, 0, 0,     0, 0, 0,     1, 8'h5A, 0, 8'h00, 0);
        tbl[17] = mk(2, 5, 8'h77, 0, 0, 0,     0, 8'h5A, 0, 8'h00, 0);
        tbl[18] = mk(0, 0, 0,     1, 5, 0,     0, 8'h5A, 0, 8'h00, 0);
        tbl[19] = mk(1, 5, 0,     0, 0, 0,     0, 8'h5A, 0, 8'h00, 0);
        tbl[20] = mk(0, 0, 0,     1, 5, 0,     0, 8'h5A, 1, 8'hA5, 0);
        tbl[21] = mk(0, 0, 0,     0, 0, 0,     1, 8'hA5, 0, 8'hA5, 0);
        tbl[22] = mk(0, 0, 0,     0, 0, 0,     0, 8'hA5, 1, 8'h77, 0);
        tbl[23] = mk(3, 5, 8'hFF, 0, 0, 0,     0, 8'hA5, 0, 8'h77, 0);
        tbl[24] = mk(1, 7, 0,     0, 0, 0,     0, 8'hA5, 0, 8'h77, 0);
        tbl[25] = mk(1, 3, 0,     0, 0, 0,     0, 8'hA5, 0, 8'h77, 0);
        tbl[26] = mk(0, 0, 0,     1, 5, 0,     1, 8'h11, 0, 8'h77, 0);
        tbl[27] = mk(0, 0, 0,     0, 0, 0,     1, 8'h5A, 0, 8'h77, 0);
        tbl[28] = mk(0, 0, 0,     0, 0, 0,     0, 8'h5A, 1, 8'h77, 0);
        tbl[29] = mk(0, 0, 0,     0, 0, 0,     0, 8'h5A, 0, 8'h77, 0);

        drv(0, 0, 0, 0, 0, 0);
        w_ena = 0; w_wea = 0; w_bea = 0; w_addra = 0; w_dina = 0;
        w_enb = 0; w_web = 0; w_beb = 0; w_addrb = 0; w_dinb = 0;
        repeat (3) tick();
        chk("reset douta", douta, 0);
        chk("reset doutb", doutb, 0);
        chk("reset valida", valida, 0);
        chk("reset validb", validb, 0);
        chk("reset collision", col, 0);
        chk("reset w_valida", w_valida, 0);
        chk("reset w_douta", w_douta, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            drv(tbl[i].opa, tbl[i].aa, tbl[i].da, tbl[i].opb, tbl[i].ab, tbl[i].db);
            tick();
            chk($sformatf("row%0d valida", i), valida, tbl[i].va);
            chk($sformatf("row%0d douta", i), douta, tbl[i].xa);
            chk($sformatf("row%0d validb", i), validb, tbl[i].vb);
            chk($sformatf("row%0d doutb", i), doutb, tbl[i].xb);
            chk($sformatf("row%0d collision", i), col, tbl[i].xc);
        end

        // Reset mid-operation: in-flight write and read are dropped, committed word survives.
        drv(2, 9, 8'h3C, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0); tick(); tick();
        drv(2, 9, 8'hC3, 1, 9, 0); tick();
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst douta", douta, 0);
        chk("rst doutb", doutb, 0);
        chk("rst valida", valida, 0);
        chk("rst validb", validb, 0);
        chk("rst collision", col, 0);
        repeat (2) begin
            tick();
            chk("rst hold validb", validb, 0);
            chk("rst hold doutb", doutb, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (4) begin
            tick();
            chk("post-rst valida", valida, 0);
            chk("post-rst validb", validb, 0);
            chk("post-rst collision", col, 0);
        end
        drv(1, 9, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0); tick(); tick();
        chk("addr9 survive valid", valida, 1);
        chk("addr9 survive data", douta, 8'h3C);

        // 16-bit WRITE_FIRST instance: byte-enable merge
        wcyc(2, 2'b11, 2, 16'h1234, 0, 0, 0, 0);
        wcyc(2, 2'b10, 2, 16'hFFFF, 0, 0, 0, 0);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        wcyc(1, 0, 2, 0, 0, 0, 0, 0);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("w16 be valid", w_valida, 1);
        chk("w16 be data", w_douta, 16'hFF34);

        // Read sampling on the commit edge returns the new word in WRITE_FIRST
        wcyc(2, 2'b11, 3, 16'h0000, 0, 0, 0, 0);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        wcyc(2, 2'b11, 3, 16'h005A, 0, 0, 0, 0);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        wcyc(0, 0, 0, 0, 1, 0, 3, 0);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("wf same-edge valid", w_validb, 1);
        chk("wf same-edge data", w_doutb, 16'h005A);

        // Same-address dual commit: A owns its byte, B fills the rest
        wcyc(2, 2'b01, 7, 16'h1111, 2, 2'b11, 7, 16'h2222);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("w16 col pre", w_col, 0);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("w16 col pulse", w_col, 1);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("w16 col end", w_col, 0);
        wcyc(1, 0, 7, 0, 0, 0, 0, 0);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        wcyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("w16 col merge valid", w_valida, 1);
        chk("w16 col merge data", w_douta, 16'h2211);

        // Randomised traffic on the default instance against the reference model
        for (int i = 0; i < 4; i++) begin
            pwa[i] = '{1'b0, 1'b0, 4'h0, 8'h00}; pwb[i] = '{1'b0, 1'b0, 4'h0, 8'h00};
            pra[i] = '{1'b0, 8'h00};             prb[i] = '{1'b0, 8'h00};
        end
        for (int i = 0; i < 16; i++) mmem[i] = 8'h00;
        e = 0; ka = 0; kb = 0; mda = 0; mdb = 0;
        for (int i = 0; i < 16; i++) rstep(2, 4'(i), 8'($urandom_range(0, 255)), 0, 0, 0);
        repeat (2) rstep(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin ra[3:2] = 2'b00; rb[3:2] = 2'b00; end
            rstep($urandom_range(0, 3), ra, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 3), rb, 8'($urandom_range(0, 255)));
        end
        repeat (3) rstep(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
